instr_sequencer: RTL and testbench

//  Instruction feeder/sequencer for processador: holds a small program memory, presents
//  one 16-bit instruction at a time on iin, and keeps each word stable for a fixed window
//  (HOLD cycles) or until the processor signals done. Supports run, single-step and halt.

---
 rtl/instr_sequencer.sv | 173 +++++++++++++++++
 tb/tb_instr_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// instr_sequencer
//   Instruction feeder for processador. It holds a small program memory and
//   presents one instruction at a time on iin. Each word stays on iin for HOLD
//   cycles, or until the processor pulses done when USE_DONE=1. The sequencer
//   supports free-running execution, single-step and halt.
//
// Ports
//   clock      rising-edge system clock
//   resetn     asynchronous reset, active high (the name is kept from the codebase)
//   load_en    write load_data to mem[load_addr]; honoured only in IDLE/HALTED
//   load_addr  program write address
//   load_data  program write data
//   start      begin free-running execution from pc (from address 0 when HALTED)
//   step       execute exactly one instruction, then return to IDLE
//   halt_req   stop at the next instruction boundary (sticky until then)
//   done       processor instruction-complete pulse (used when USE_DONE=1)
//   iin        instruction presented to processador
//   pc         address of the word on iin / next word to fetch
//   busy       high in EXEC
//   halted     high in HALTED
module instr_sequencer #(
  parameter int            IW        = 16,
  parameter int            AW        = 4,
  parameter int            HOLD      = 4,
  parameter int            USE_DONE  = 0,
  parameter logic [IW-1:0] HALT_WORD = {IW{1'b1}}
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [IW-1:0] load_data,
  input  logic          start,
  input  logic          step,
  input  logic          halt_req,
  input  logic          done,
  output logic [IW-1:0] iin,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          halted
);

  localparam int DEPTH = 2 ** AW;
  localparam int CW    = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXEC   = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [IW-1:0] iin_q, iin_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          step_mode_q, step_mode_d;
  logic          halt_pend_q, halt_pend_d;

  logic [IW-1:0] mem [DEPTH];
  logic          mem_we;
  logic [AW-1:0] pc_inc;
  logic [IW-1:0] word_cur;
  logic [IW-1:0] word_next;
  logic [IW-1:0] word_zero;
  logic          boundary;
  logic          halt_any;

  // Reads are combinational so a fetch at an edge sees the memory contents
  // from before any write at that same edge.
  assign pc_inc    = pc_q + AW'(1);
  assign word_cur  = mem[pc_q];
  assign word_next = mem[pc_inc];
  assign word_zero = mem[AW'(0)];
  assign mem_we    = load_en && (state_q != ST_EXEC);

  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[load_addr] <= load_data;
    end
  end

  assign boundary = (USE_DONE != 0) ? done : (cnt_q == '0);
  // A halt request seen in the boundary cycle itself still stops at that boundary.
  assign halt_any = halt_pend_q | halt_req;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    iin_d       = iin_q;
    cnt_d       = cnt_q;
    step_mode_d = step_mode_q;
    halt_pend_d = halt_pend_q;

    case (state_q)
      ST_IDLE: begin
        if (start || step) begin
          if (word_cur == HALT_WORD) begin
            state_d = ST_HALTED;
          end else begin
            iin_d       = word_cur;
            cnt_d       = HOLD_LAST;
            step_mode_d = step & ~start;
            state_d     = ST_EXEC;
          end
        end
      end

      ST_EXEC: begin
        if (boundary) begin
          pc_d = pc_inc;
          if (halt_any) begin
            halt_pend_d = 1'b0;
            state_d     = ST_HALTED;
          end else if (word_next == HALT_WORD) begin
            state_d = ST_HALTED;
          end else if (step_mode_q) begin
            state_d = ST_IDLE;
          end else begin
            iin_d = word_next;
            cnt_d = HOLD_LAST;
          end
        end else begin
          halt_pend_d = halt_any;
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
          end
        end
      end

      ST_HALTED: begin
        // Restart always begins at address 0, with the same halt-word check.
        if (start) begin
          pc_d = '0;
          if (word_zero != HALT_WORD) begin
            iin_d       = word_zero;
            cnt_d       = HOLD_LAST;
            step_mode_d = 1'b0;
            state_d     = ST_EXEC;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge resetn) begin
    if (resetn) begin
      state_q     <= ST_IDLE;
      pc_q        <= '0;
      iin_q       <= '0;
      cnt_q       <= '0;
      step_mode_q <= 1'b0;
      halt_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      iin_q       <= iin_d;
      cnt_q       <= cnt_d;
      step_mode_q <= step_mode_d;
      halt_pend_q <= halt_pend_d;
    end
  end

  assign iin    = iin_q;
  assign pc     = pc_q;
  assign busy   = (state_q == ST_EXEC);
  assign halted = (state_q == ST_HALTED);

endmodule

// File: tb/tb_instr_sequencer.sv
module tb_instr_sequencer;

  logic        clock;
  logic        resetn;

  // Timed instance (USE_DONE=0, HOLD=4)
  logic        load_en, start, step, halt_req, done;
  logic [3:0]  load_addr;
  logic [15:0] load_data;
  logic [15:0] iin;
  logic [3:0]  pc;
  logic        busy, halted;

  // Done-driven instance (USE_DONE=1)
  logic        d_load_en, d_start, d_step, d_halt_req, d_done;
  logic [3:0]  d_load_addr;
  logic [15:0] d_load_data;
  logic [15:0] d_iin;
  logic [3:0]  d_pc;
  logic        d_busy, d_halted;

  int checks   = 0;
  int failures = 0;

  instr_sequencer #(.IW(16), .AW(4), .HOLD(4), .USE_DONE(0)) u_dut (
    .clock(clock), .resetn(resetn),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .start(start), .step(step), .halt_req(halt_req), .done(done),
    .iin(iin), .pc(pc), .busy(busy), .halted(halted)
  );

  instr_sequencer #(.IW(16), .AW(4), .HOLD(4), .USE_DONE(1)) u_dut_done (
    .clock(clock), .resetn(resetn),
    .load_en(d_load_en), .load_addr(d_load_addr), .load_data(d_load_data),
    .start(d_start), .step(d_step), .halt_req(d_halt_req), .done(d_done),
    .iin(d_iin), .pc(d_pc), .busy(d_busy), .halted(d_halted)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one rising edge; inputs and samples live 1 time unit after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load_word(input logic [3:0] a, input logic [15:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    tick();
    load_en   = 1'b0;
  endtask

  task automatic d_load_word(input logic [3:0] a, input logic [15:0] d);
    d_load_en   = 1'b1;
    d_load_addr = a;
    d_load_data = d;
    tick();
    d_load_en   = 1'b0;
  endtask

  task automatic do_reset();
    resetn = 1'b1;
    tick();
    resetn = 1'b0;
    tick();
  endtask

  logic [15:0] prog [4];
  logic [15:0] exp_w;

  initial begin
    prog[0] = 16'hA01C; prog[1] = 16'hA40A; prog[2] = 16'h8400; prog[3] = 16'hFFFF;
    load_en = 0; start = 0; step = 0; halt_req = 0; done = 0;
    load_addr = '0; load_data = '0;
    d_load_en = 0; d_start = 0; d_step = 0; d_halt_req = 0; d_done = 0;
    d_load_addr = '0; d_load_data = '0;
    resetn = 1'b1;
    #12;
    check_eq("reset_iin", {16'h0, iin}, 32'h0);
    check_eq("reset_pc", {28'h0, pc}, 32'h0);
    check_eq("reset_busy", {31'h0, busy}, 32'h0);
    check_eq("reset_halted", {31'h0, halted}, 32'h0);
    resetn = 1'b0;
    tick();

    // 1: free run, HOLD=4
    for (int i = 0; i < 4; i++) load_word(4'(i), prog[i]);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int w = 0; w < 3; w++) begin
      for (int c = 0; c < 4; c++) begin
        check_eq($sformatf("run_w%0d_c%0d", w, c), {16'h0, iin}, {16'h0, prog[w]});
        check_eq("run_busy", {31'h0, busy}, 32'h1);
        tick();
      end
    end
    check_eq("run_halted", {31'h0, halted}, 32'h1);
    check_eq("run_pc", {28'h0, pc}, 32'h3);
    check_eq("run_iin_hold", {16'h0, iin}, 32'h8400);
    tick(); tick();
    check_eq("run_iin_hold2", {16'h0, iin}, 32'h8400);
    $display("test1 free run: iin=%h pc=%0d halted=%0d", iin, pc, halted);

    // 2: single step
    do_reset();
    for (int s = 0; s < 3; s++) begin
      step = 1'b1;
      tick();
      step = 1'b0;
      check_eq("step_iin", {16'h0, iin}, {16'h0, prog[s]});
      check_eq("step_busy", {31'h0, busy}, 32'h1);
      for (int c = 0; c < 4; c++) tick();
      check_eq("step_pc", {28'h0, pc}, 32'(s + 1));
      check_eq("step_busy_after", {31'h0, busy}, 32'h0);
      check_eq("step_halted", {31'h0, halted}, (s == 2) ? 32'h1 : 32'h0);
      $display("test2 step %0d: iin=%h pc=%0d halted=%0d", s, iin, pc, halted);
    end
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
    check_eq("step4_halted", {31'h0, halted}, 32'h1);
    check_eq("step4_busy", {31'h0, busy}, 32'h0);
    check_eq("step4_iin", {16'h0, iin}, 32'h8400);

    // 3: halt request in 2nd cycle of the first word
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    check_eq("halt_iin_c2", {16'h0, iin}, 32'hA01C);
    tick();
    check_eq("halt_iin_c3", {16'h0, iin}, 32'hA01C);
    check_eq("halt_busy_c3", {31'h0, busy}, 32'h1);
    tick();
    check_eq("halt_halted", {31'h0, halted}, 32'h1);
    check_eq("halt_pc", {28'h0, pc}, 32'h1);
    check_eq("halt_iin", {16'h0, iin}, 32'hA01C);
    $display("test3 halt_req: iin=%h pc=%0d halted=%0d", iin, pc, halted);

    // 4: full memory, wraparound; loads honoured while HALTED
    for (int i = 0; i < 16; i++) load_word(4'(i), 16'h1000 + 16'(i));
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int w = 0; w < 16; w++) begin
      check_eq("wrap_iin", {16'h0, iin}, 32'h1000 + 32'(w));
      check_eq("wrap_pc", {28'h0, pc}, 32'(w));
      for (int c = 0; c < 4; c++) tick();
    end
    check_eq("wrap_pc0", {28'h0, pc}, 32'h0);
    check_eq("wrap_iin0", {16'h0, iin}, 32'h1000);
    check_eq("wrap_busy", {31'h0, busy}, 32'h1);
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    begin
      int n;
      n = 0;
      while (!halted && n < 10) begin
        tick();
        n++;
      end
      check_eq("wrap_halt_timeout", {31'h0, halted}, 32'h1);
    end
    check_eq("wrap_halt_pc", {28'h0, pc}, 32'h1);
    $display("test4 wrap: iin=%h pc=%0d halted=%0d", iin, pc, halted);

    // 5: done-driven advance on the second instance
    d_load_word(4'd0, 16'h1111);
    d_load_word(4'd1, 16'h2222);
    d_load_word(4'd2, 16'h3333);
    d_load_word(4'd3, 16'hFFFF);
    d_done = 1'b1;
    tick();
    d_done = 1'b0;
    check_eq("done_idle_busy", {31'h0, d_busy}, 32'h0);
    check_eq("done_idle_pc", {28'h0, d_pc}, 32'h0);
    check_eq("done_idle_iin", {16'h0, d_iin}, 32'h0);
    d_start = 1'b1;
    tick();
    d_start = 1'b0;
    check_eq("done_e0", {16'h0, d_iin}, 32'h1111);
    for (int t = 0; t < 10; t++) begin
      d_done = (t == 2 || t == 6);
      tick();
      d_done = 1'b0;
      exp_w = (t + 1 >= 7) ? 16'h3333 : (t + 1 >= 3) ? 16'h2222 : 16'h1111;
      check_eq($sformatf("done_e%0d", t + 1), {16'h0, d_iin}, {16'h0, exp_w});
    end
    check_eq("done_busy", {31'h0, d_busy}, 32'h1);
    d_done = 1'b1;
    tick();
    d_done = 1'b0;
    check_eq("done_halted", {31'h0, d_halted}, 32'h1);
    check_eq("done_pc", {28'h0, d_pc}, 32'h3);
    check_eq("done_iin", {16'h0, d_iin}, 32'h3333);
    $display("test5 use_done: iin=%h pc=%0d halted=%0d", d_iin, d_pc, d_halted);

    // 6: reset mid-EXEC, memory intact, EXEC loads ignored
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("rst_run_iin", {16'h0, iin}, 32'h1000);
    load_en = 1'b1; load_addr = 4'd2; load_data = 16'hBEEF;
    tick();
    load_en = 1'b0;
    resetn = 1'b1;
    #1;
    check_eq("rst_async_iin", {16'h0, iin}, 32'h0);
    check_eq("rst_async_pc", {28'h0, pc}, 32'h0);
    check_eq("rst_async_busy", {31'h0, busy}, 32'h0);
    resetn = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("rst_replay_w0", {16'h0, iin}, 32'h1000);
    for (int c = 0; c < 4; c++) tick();
    check_eq("rst_replay_w1", {16'h0, iin}, 32'h1001);
    for (int c = 0; c < 4; c++) tick();
    check_eq("rst_replay_w2", {16'h0, iin}, 32'h1002);
    check_eq("rst_replay_pc", {28'h0, pc}, 32'h2);
    $display("test6 reset: iin=%h pc=%0d busy=%0d", iin, pc, busy);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
